// File: rtl/mod_slave_arb.sv
// mod_slave_arb: two-port arbiter and sequencer for one memory-mapped slave.
// Port A (CPU data) and port B (debug/DMA) each issue word transactions; one
// is granted at a time, the slave is driven for 1+WAIT_CYCLES cycles, and the
// result is returned to the winner with a one-cycle ack.
// Optional feature macro: PLP_ARB_RR_EN -- when defined, ties are broken
// round-robin via last_grant; when undefined, port A has fixed priority.
module mod_slave_arb #(
  parameter int WAIT_CYCLES = 0,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_drw,
  input  logic [31:0]       a_din,
  output logic [31:0]       a_dout,
  output logic              a_ack,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_drw,
  input  logic [31:0]       b_din,
  output logic [31:0]       b_dout,
  output logic              b_ack,
  output logic              s_de,
  output logic [ADDR_W-1:0] s_daddr,
  output logic              s_drw,
  output logic [31:0]       s_din,
  input  logic [31:0]       s_dout,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  // Returns 1 when port B wins; tie_b decides only when both ports request.
  function automatic logic pick_b(input logic req_a, input logic req_b, input logic tie_b);
    logic res;
    if (req_a && req_b) begin
      res = tie_b;
    end else begin
      res = req_b;
    end
    return res;
  endfunction

  state_t            state_r, state_next_s;
  logic [3:0]        cnt_r, cnt_next_s;
  logic              grant_r, grant_next_s;
  logic              last_grant_r, last_grant_next_s;
  logic [ADDR_W-1:0] addr_r, addr_next_s;
  logic              drw_r, drw_next_s;
  logic [31:0]       din_r, din_next_s;
  logic              de_r, de_next_s;
  logic              s_drw_r, s_drw_next_s;
  logic              busy_r, busy_next_s;
  logic              a_ack_r, a_ack_next_s;
  logic              b_ack_r, b_ack_next_s;
  logic [31:0]       a_dout_r, a_dout_next_s;
  logic [31:0]       b_dout_r, b_dout_next_s;
  logic              tie_b_s;
  logic              win_b_s;
  logic [31:0]       rdata_s;

  // Next state, latched transaction fields and next values of all registered outputs.
  always_comb begin
    state_next_s      = state_r;
    cnt_next_s        = cnt_r;
    grant_next_s      = grant_r;
    last_grant_next_s = last_grant_r;
    addr_next_s       = addr_r;
    drw_next_s        = drw_r;
    din_next_s        = din_r;
    de_next_s         = 1'b0;
    s_drw_next_s      = 1'b0;
    a_ack_next_s      = 1'b0;
    b_ack_next_s      = 1'b0;
    a_dout_next_s     = a_dout_r;
    b_dout_next_s     = b_dout_r;
`ifdef PLP_ARB_RR_EN
    tie_b_s           = (last_grant_r == GRANT_A);
`else
    tie_b_s           = 1'b0;
`endif
    win_b_s           = pick_b(a_req, b_req, tie_b_s);
    // Writes return zero; reads return whatever the slave presents now.
    rdata_s           = drw_r ? 32'd0 : s_dout;

    case (state_r)
      ST_IDLE: begin
        if (a_req || b_req) begin
          grant_next_s      = win_b_s;
          last_grant_next_s = win_b_s;
          if (win_b_s) begin
            addr_next_s = b_addr;
            drw_next_s  = b_drw;
            din_next_s  = b_din;
          end else begin
            addr_next_s = a_addr;
            drw_next_s  = a_drw;
            din_next_s  = a_din;
          end
          cnt_next_s   = 4'(WAIT_CYCLES);
          de_next_s    = 1'b1;
          s_drw_next_s = win_b_s ? b_drw : a_drw;
          state_next_s = ST_SERVE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SERVE: begin
        if (cnt_r == 4'd0) begin
          state_next_s = ST_RESP;
          if (grant_r == GRANT_B) begin
            b_ack_next_s  = 1'b1;
            b_dout_next_s = rdata_s;
          end else begin
            a_ack_next_s  = 1'b1;
            a_dout_next_s = rdata_s;
          end
        end else begin
          cnt_next_s   = cnt_r - 4'd1;
          de_next_s    = 1'b1;
          s_drw_next_s = drw_r;
        end
      end
      ST_RESP: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase

    busy_next_s = (state_next_s != ST_IDLE);
  end

  // State and output registers; reset abandons any transaction without an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      grant_r      <= GRANT_A;
      last_grant_r <= GRANT_B;
      addr_r       <= '0;
      drw_r        <= 1'b0;
      din_r        <= 32'd0;
      de_r         <= 1'b0;
      s_drw_r      <= 1'b0;
      busy_r       <= 1'b0;
      a_ack_r      <= 1'b0;
      b_ack_r      <= 1'b0;
      a_dout_r     <= 32'd0;
      b_dout_r     <= 32'd0;
    end else begin
      state_r      <= state_next_s;
      cnt_r        <= cnt_next_s;
      grant_r      <= grant_next_s;
      last_grant_r <= last_grant_next_s;
      addr_r       <= addr_next_s;
      drw_r        <= drw_next_s;
      din_r        <= din_next_s;
      de_r         <= de_next_s;
      s_drw_r      <= s_drw_next_s;
      busy_r       <= busy_next_s;
      a_ack_r      <= a_ack_next_s;
      b_ack_r      <= b_ack_next_s;
      a_dout_r     <= a_dout_next_s;
      b_dout_r     <= b_dout_next_s;
    end
  end

  assign s_de    = de_r;
  assign s_daddr = addr_r;
  assign s_drw   = s_drw_r;
  assign s_din   = din_r;
  assign busy    = busy_r;
  assign a_ack   = a_ack_r;
  assign b_ack   = b_ack_r;
  assign a_dout  = a_dout_r;
  assign b_dout  = b_dout_r;

endmodule

// File: tb/tb_mod_slave_arb.sv
// tb_mod_slave_arb: directed, table-driven bench for mod_slave_arb.
// dut0 uses WAIT_CYCLES=0, dut3 uses WAIT_CYCLES=3; both share the requester
// inputs and reset. Tie-order expectations follow PLP_ARB_RR_EN.
module tb_mod_slave_arb;

  logic        clk;
  logic        rst;
  logic        a_req, a_drw, b_req, b_drw;
  logic [31:0] a_addr, a_din, b_addr, b_din;

  logic [31:0] a_dout0, b_dout0, s_daddr0, s_din0, s_dout0;
  logic        a_ack0, b_ack0, s_de0, s_drw0, busy0;
  logic [31:0] a_dout3, b_dout3, s_daddr3, s_din3, s_dout3;
  logic        a_ack3, b_ack3, s_de3, s_drw3, busy3;

  int checks = 0;
  int errors = 0;

  // Slave read data as a function of address.
  function automatic logic [31:0] slave_model(input logic [31:0] addr);
    logic [31:0] d;
    case (addr)
      32'd0:   d = 32'h0000_0202;
      32'd4:   d = 32'h017d_7840;
      default: d = addr ^ 32'hC0DE_0000;
    endcase
    return d;
  endfunction

  assign s_dout0 = slave_model(s_daddr0);
  assign s_dout3 = slave_model(s_daddr3);

  mod_slave_arb #(.WAIT_CYCLES(0), .ADDR_W(32)) dut0 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_addr(a_addr), .a_drw(a_drw), .a_din(a_din),
    .a_dout(a_dout0), .a_ack(a_ack0),
    .b_req(b_req), .b_addr(b_addr), .b_drw(b_drw), .b_din(b_din),
    .b_dout(b_dout0), .b_ack(b_ack0),
    .s_de(s_de0), .s_daddr(s_daddr0), .s_drw(s_drw0), .s_din(s_din0),
    .s_dout(s_dout0), .busy(busy0)
  );

  mod_slave_arb #(.WAIT_CYCLES(3), .ADDR_W(32)) dut3 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_addr(a_addr), .a_drw(a_drw), .a_din(a_din),
    .a_dout(a_dout3), .a_ack(a_ack3),
    .b_req(b_req), .b_addr(b_addr), .b_drw(b_drw), .b_din(b_din),
    .b_dout(b_dout3), .b_ack(b_ack3),
    .s_de(s_de3), .s_daddr(s_daddr3), .s_drw(s_drw3), .s_din(s_din3),
    .s_dout(s_dout3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        a_req;
    logic [31:0] a_addr;
    logic        a_drw;
    logic [31:0] a_din;
    logic        b_req;
    logic [31:0] b_addr;
    logic        b_drw;
    logic [31:0] b_din;
    logic        e_de;
    logic        e_drw;
    logic [31:0] e_addr;
    logic [31:0] e_din;
    logic        e_busy;
    logic        e_aack;
    logic [31:0] e_adout;
    logic        e_back;
    logic [31:0] e_bdout;
  } vec_t;

  function automatic vec_t mk(
    input logic ar, input logic [31:0] aa, input logic ad, input logic [31:0] ai,
    input logic br, input logic [31:0] ba, input logic bd, input logic [31:0] bi,
    input logic ede, input logic edrw, input logic [31:0] eaddr, input logic [31:0] edin,
    input logic ebusy, input logic eaack, input logic [31:0] eadout,
    input logic eback, input logic [31:0] ebdout);
    vec_t v;
    v.a_req = ar;  v.a_addr = aa;  v.a_drw = ad;  v.a_din = ai;
    v.b_req = br;  v.b_addr = ba;  v.b_drw = bd;  v.b_din = bi;
    v.e_de = ede;  v.e_drw = edrw; v.e_addr = eaddr; v.e_din = edin;
    v.e_busy = ebusy; v.e_aack = eaack; v.e_adout = eadout;
    v.e_back = eback; v.e_bdout = ebdout;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %b required %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_req = 1'b0; a_addr = 32'd0; a_drw = 1'b0; a_din = 32'd0;
    b_req = 1'b0; b_addr = 32'd0; b_drw = 1'b0; b_din = 32'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic check_zero(input string tag, input logic aack, input logic back,
                            input logic de, input logic drw, input logic bsy,
                            input logic [31:0] adout, input logic [31:0] bdout,
                            input logic [31:0] addr, input logic [31:0] din);
    chkb({tag, " a_ack"}, aack, 1'b0);
    chkb({tag, " b_ack"}, back, 1'b0);
    chkb({tag, " s_de"}, de, 1'b0);
    chkb({tag, " s_drw"}, drw, 1'b0);
    chkb({tag, " busy"}, bsy, 1'b0);
    chk({tag, " a_dout"}, adout, 32'd0);
    chk({tag, " b_dout"}, bdout, 32'd0);
    chk({tag, " s_daddr"}, addr, 32'd0);
    chk({tag, " s_din"}, din, 32'd0);
  endtask

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vt[12];
  logic exp_b[6];

  initial begin
    int n;
    int last_c;
    int acks;

    vt[0]  = mk(1'b1, 32'd0, 1'b0, 32'd0,  1'b0, 32'd0, 1'b0, 32'd0,
                1'b1, 1'b0, 32'd0, 32'd0,  1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    vt[1]  = mk(1'b1, 32'd0, 1'b0, 32'd0,  1'b0, 32'd0, 1'b0, 32'd0,
                1'b0, 1'b0, 32'd0, 32'd0,  1'b1, 1'b1, 32'h0000_0202, 1'b0, 32'd0);
    vt[2]  = mk(1'b0, 32'd0, 1'b0, 32'd0,  1'b0, 32'd0, 1'b0, 32'd0,
                1'b0, 1'b0, 32'd0, 32'd0,  1'b0, 1'b0, 32'h0000_0202, 1'b0, 32'd0);
    vt[3]  = mk(1'b0, 32'd0, 1'b0, 32'd0,  1'b1, 32'd8, 1'b1, 32'hDEAD_BEEF,
                1'b1, 1'b1, 32'd8, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0000_0202, 1'b0, 32'd0);
    vt[4]  = mk(1'b0, 32'd0, 1'b0, 32'd0,  1'b1, 32'd8, 1'b1, 32'hDEAD_BEEF,
                1'b0, 1'b0, 32'd0, 32'd0,  1'b1, 1'b0, 32'h0000_0202, 1'b1, 32'd0);
    vt[5]  = mk(1'b0, 32'd0, 1'b0, 32'd0,  1'b0, 32'd0, 1'b0, 32'd0,
                1'b0, 1'b0, 32'd0, 32'd0,  1'b0, 1'b0, 32'h0000_0202, 1'b0, 32'd0);
    vt[6]  = mk(1'b0, 32'd0, 1'b0, 32'd0,  1'b1, 32'd12, 1'b0, 32'd0,
                1'b1, 1'b0, 32'd12, 32'd0, 1'b1, 1'b0, 32'h0000_0202, 1'b0, 32'd0);
    vt[7]  = mk(1'b0, 32'd0, 1'b0, 32'd0,  1'b1, 32'd12, 1'b0, 32'd0,
                1'b0, 1'b0, 32'd0, 32'd0,  1'b1, 1'b0, 32'h0000_0202, 1'b1, 32'hC0DE_000C);
    vt[8]  = mk(1'b0, 32'd0, 1'b0, 32'd0,  1'b0, 32'd0, 1'b0, 32'd0,
                1'b0, 1'b0, 32'd0, 32'd0,  1'b0, 1'b0, 32'h0000_0202, 1'b0, 32'hC0DE_000C);
    vt[9]  = mk(1'b1, 32'd16, 1'b1, 32'h1234_5678, 1'b0, 32'd0, 1'b0, 32'd0,
                1'b1, 1'b1, 32'd16, 32'h1234_5678, 1'b1, 1'b0, 32'h0000_0202, 1'b0, 32'hC0DE_000C);
    vt[10] = mk(1'b1, 32'd16, 1'b1, 32'h1234_5678, 1'b0, 32'd0, 1'b0, 32'd0,
                1'b0, 1'b0, 32'd0, 32'd0,  1'b1, 1'b1, 32'd0, 1'b0, 32'hC0DE_000C);
    vt[11] = mk(1'b0, 32'd0, 1'b0, 32'd0,  1'b0, 32'd0, 1'b0, 32'd0,
                1'b0, 1'b0, 32'd0, 32'd0,  1'b0, 1'b0, 32'd0, 1'b0, 32'hC0DE_000C);

`ifdef PLP_ARB_RR_EN
    exp_b = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_b = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

    // Reset state of both instances.
    idle_inputs();
    do_reset();
    check_zero("rst0", a_ack0, b_ack0, s_de0, s_drw0, busy0, a_dout0, b_dout0, s_daddr0, s_din0);
    check_zero("rst3", a_ack3, b_ack3, s_de3, s_drw3, busy3, a_dout3, b_dout3, s_daddr3, s_din3);

    // Table: inputs held for one cycle, outputs checked after the following edge.
    for (int i = 0; i < 12; i++) begin
      a_req = vt[i].a_req; a_addr = vt[i].a_addr; a_drw = vt[i].a_drw; a_din = vt[i].a_din;
      b_req = vt[i].b_req; b_addr = vt[i].b_addr; b_drw = vt[i].b_drw; b_din = vt[i].b_din;
      step();
      chkb($sformatf("v%0d s_de", i), s_de0, vt[i].e_de);
      chkb($sformatf("v%0d s_drw", i), s_drw0, vt[i].e_drw);
      chkb($sformatf("v%0d busy", i), busy0, vt[i].e_busy);
      chkb($sformatf("v%0d a_ack", i), a_ack0, vt[i].e_aack);
      chkb($sformatf("v%0d b_ack", i), b_ack0, vt[i].e_back);
      chk($sformatf("v%0d a_dout", i), a_dout0, vt[i].e_adout);
      chk($sformatf("v%0d b_dout", i), b_dout0, vt[i].e_bdout);
      if (vt[i].e_de) begin
        chk($sformatf("v%0d s_daddr", i), s_daddr0, vt[i].e_addr);
      end
      if (vt[i].e_de && vt[i].e_drw) begin
        chk($sformatf("v%0d s_din", i), s_din0, vt[i].e_din);
      end
    end

    // Continuous simultaneous requests: grant order and 3-cycle throughput.
    idle_inputs();
    do_reset();
    a_req = 1'b1; a_addr = 32'd0;
    b_req = 1'b1; b_addr = 32'd4;
    n = 0;
    last_c = 0;
    for (int c = 1; c <= 40 && n < 6; c++) begin
      step();
      if (a_ack0 || b_ack0) begin
        chkb($sformatf("tie%0d a_ack", n), a_ack0, ~exp_b[n]);
        chkb($sformatf("tie%0d b_ack", n), b_ack0, exp_b[n]);
        if (exp_b[n]) begin
          chk($sformatf("tie%0d b_dout", n), b_dout0, 32'h017d_7840);
        end else begin
          chk($sformatf("tie%0d a_dout", n), a_dout0, 32'h0000_0202);
        end
        if (n > 0) begin
          chk($sformatf("tie%0d spacing", n), 32'(c - last_c), 32'd3);
        end
        last_c = c;
        n++;
      end
    end
    chk("tie ack count", 32'(n), 32'd6);

    // WAIT_CYCLES=3 read: SERVE cycles 1-4, ack in cycle 5, busy 1-5.
    idle_inputs();
    do_reset();
    a_req = 1'b1; a_addr = 32'd4;
    for (int k = 1; k <= 6; k++) begin
      step();
      chkb($sformatf("w3 c%0d s_de", k), s_de3, (k <= 4));
      chkb($sformatf("w3 c%0d a_ack", k), a_ack3, (k == 5));
      chkb($sformatf("w3 c%0d busy", k), busy3, (k <= 5));
      chkb($sformatf("w3 c%0d b_ack", k), b_ack3, 1'b0);
      if (k <= 4) begin
        chk($sformatf("w3 c%0d s_daddr", k), s_daddr3, 32'd4);
      end
      if (k == 5) begin
        chk("w3 a_dout", a_dout3, 32'h017d_7840);
        a_req = 1'b0;
      end
    end

    // Reset during SERVE: no ack, everything cleared, then a clean transaction.
    idle_inputs();
    do_reset();
    a_req = 1'b1; a_addr = 32'd0;
    step();
    step();
    chkb("pre a_ack", a_ack0, 1'b1);
    chk("pre a_dout", a_dout0, 32'h0000_0202);
    a_req = 1'b0;
    step();
    a_req = 1'b1; a_addr = 32'd4;
    step();
    chkb("mid s_de", s_de0, 1'b1);
    rst = 1'b1;
    step();
    check_zero("midrst", a_ack0, b_ack0, s_de0, s_drw0, busy0, a_dout0, b_dout0, s_daddr0, s_din0);
    rst = 1'b0;
    a_addr = 32'd0;
    step();
    chkb("post c1 s_de", s_de0, 1'b1);
    chkb("post c1 a_ack", a_ack0, 1'b0);
    step();
    chkb("post c2 a_ack", a_ack0, 1'b1);
    chk("post c2 a_dout", a_dout0, 32'h0000_0202);
    a_req = 1'b0;
    step();
    chkb("post c3 a_ack", a_ack0, 1'b0);

    // Requester drops a_req during SERVE: one ack, no follow-on transaction.
    idle_inputs();
    do_reset();
    a_req = 1'b1; a_addr = 32'd0;
    step();
    a_req = 1'b0;
    acks = 0;
    for (int k = 2; k <= 7; k++) begin
      step();
      if (a_ack0) acks++;
      if (k == 2) begin
        chkb("drop ack", a_ack0, 1'b1);
        chk("drop a_dout", a_dout0, 32'h0000_0202);
      end
      if (k >= 3) begin
        chkb($sformatf("drop c%0d busy", k), busy0, 1'b0);
        chkb($sformatf("drop c%0d s_de", k), s_de0, 1'b0);
      end
    end
    chk("drop ack count", 32'(acks), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_slave_arb.md
# mod_slave_arb

Two-port arbiter and sequencer for a single memory-mapped slave (CPU-ID block, timers, other simple peripherals) on the PLP data bus. It accepts word transactions from two requesters: port A, the CPU data side, and port B, the debug/DMA side. It grants one transaction at a time and drives the slave's `de`/`daddr`/`drw`/`din` signals for the required number of cycles. It captures the slave's `dout` and returns it with a one-cycle acknowledge.

## Interface
Parameters:
- `WAIT_CYCLES`, default 0: extra cycles the slave select is held before read data is sampled (0–15).
- `ADDR_W`, default 32: address width passed to the slave.

Ports:
- `clk`  in  1  system clock; everything is sampled on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `a_req`  in  1  port A request; held high until `a_ack`.
- `a_addr`  in  ADDR_W  port A word address.
- `a_drw`  in  1  port A direction: 1 = write, 0 = read.
- `a_din`  in  32  port A write data.
- `a_dout`  out  32  port A read data; valid when `a_ack` = 1.
- `a_ack`  out  1  port A one-cycle completion pulse.
- `b_req`, `b_addr`, `b_drw`, `b_din`, `b_dout`, `b_ack`: same as port A, for port B.
- `s_de`  out  1  slave select.
- `s_daddr`  out  ADDR_W  slave address.
- `s_drw`  out  1  slave write strobe.
- `s_din`  out  32  slave write data.
- `s_dout`  in  32  slave read data (combinational from `s_daddr`).
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states are IDLE, SERVE and RESP.
- IDLE: if any request is high, select a winner and latch its addr/drw/din into internal registers, then go to SERVE. A single request wins outright.
  - With simultaneous requests, the winner is determined by the arbitration policy (see Configuration).
  - Record the winner in the `last_grant` register.
  - If no request is high, stay in IDLE.
- SERVE:
  - Drive `s_de`=1 with the latched address and data.
  - Drive `s_drw` = latched drw.
  - Load the wait counter with `WAIT_CYCLES` on entry and decrement it each cycle.
  - When the counter is 0, capture `s_dout` into the response register and go to RESP.
  - For writes, capture 0 instead of `s_dout`.
- RESP: pulse the winner's ack for exactly one cycle and drive its `dout` from the response register, then go to IDLE.
- `a_dout`/`b_dout` hold their last value between responses. The port that did not win keeps its previous `dout`.
- A requester must drop `req` in the cycle after its ack. A `req` still high in IDLE after that is treated as a new transaction.
- If a requester drops `req` during SERVE, the transaction still completes and the ack still pulses; the requester ignores it.
- Requester inputs are not observed outside IDLE; the latched values are used throughout.
- `s_drw` is never high unless `s_de` is high.

## Timing
- Reset values: all outputs 0, FSM in IDLE, `last_grant` = B (so A wins the first tie), wait counter 0, response registers 0.
- Reset mid-transaction: return to IDLE on the next edge, issue no ack, deassert `s_de` immediately after that edge, and clear the response registers.
- Latency, with the request sampled in IDLE at cycle 0:
  - SERVE occupies cycles 1 … 1+WAIT_CYCLES.
  - The ack occurs at cycle 2+WAIT_CYCLES.
  - The earliest next grant is at cycle 3+WAIT_CYCLES.
- Slave-side behaviour during SERVE:
  - The write takes effect on every SERVE cycle the slave samples. Slaves must tolerate a repeated write of the same data.
  - Read data is sampled on the last SERVE cycle only.
- Throughput for back-to-back transactions: one transaction per 3+WAIT_CYCLES cycles.
- `busy` = 1 in SERVE and RESP.

## Configuration
- `PLP_ARB_RR_EN` defined: round-robin arbitration. On a tie in IDLE, the port not recorded in `last_grant` wins, so continuous dual requests alternate A, B, A, B…
- `PLP_ARB_RR_EN` undefined: fixed priority, where A always wins ties. `last_grant` is still recorded but unused, and B can starve under continuous A traffic.

## Test plan
- Reset, then a single A read of `a_addr`=0 with the slave returning 32'h00000202 (WAIT_CYCLES=0):
  - `s_de` is high in cycle 1.
  - `a_ack` pulses in cycle 2 with `a_dout`=32'h00000202.
  - `b_ack` stays 0.
- B write to `b_addr`=8, `b_din`=32'hDEADBEEF:
  - `s_de`=`s_drw`=1 in SERVE with the correct addr/data.
  - `b_ack` pulses with `b_dout`=0.
  - `a_dout` is unchanged.
- A and B request simultaneously and continuously for 6 transactions:
  - With `PLP_ARB_RR_EN`, the grant order is A, B, A, B, A, B.
  - Without it, all six go to A and B is never acked.
- WAIT_CYCLES=3, A read of addr 4 (slave returns 32'h017d7840):
  - SERVE lasts 4 cycles.
  - The ack is at cycle 5 with data 32'h017d7840.
  - `busy` is high for cycles 1–5.
- Assert `rst` during SERVE of an A read:
  - No `a_ack` occurs.
  - `s_de`=0 after the reset edge and all outputs are 0.
  - A new A request afterwards completes normally with correct latency.
- A drops `a_req` during SERVE: `a_ack` still pulses once, and no second transaction is started.
